// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, runs held req/ack transactions to imem,
// absorbs decode stalls with a 1-entry skid and squashes stale responses on redirect.
// Optional FETCH_PERF_EN adds saturating bubble/drop counters.
module fetch_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = {DATA_WIDTH{1'b0}},
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stallF,
  input  logic                  redirectE,
  input  logic [DATA_WIDTH-1:0] redirect_pcE,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] instrF,
  output logic [DATA_WIDTH-1:0] pcF,
  output logic [DATA_WIDTH-1:0] pc_plus4F,
  output logic                  validF
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_bubbles,
  output logic [31:0]           perf_drops
`endif
);

  localparam logic [DATA_WIDTH-1:0] PC_INC = DATA_WIDTH'(32'd4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SKID = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t                r_state,      w_state_nxt;
  logic [DATA_WIDTH-1:0] r_fetch_pc,   w_fetch_pc_nxt;
  logic                  r_mem_req,    w_mem_req_nxt;
  logic [DATA_WIDTH-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic                  r_validF,     w_validF_nxt;
  logic [DATA_WIDTH-1:0] r_instrF,     w_instrF_nxt;
  logic [DATA_WIDTH-1:0] r_pcF,        w_pcF_nxt;
  logic [DATA_WIDTH-1:0] r_pc_plus4F,  w_pc_plus4F_nxt;
  logic [DATA_WIDTH-1:0] r_skid_instr, w_skid_instr_nxt;
  logic [DATA_WIDTH-1:0] r_skid_pc,    w_skid_pc_nxt;
  logic                  w_f_accept;

  assign w_f_accept = !r_validF || !stallF;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_fetch_pc   <= RESET_PC;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= RESET_PC;
      r_validF     <= 1'b0;
      r_instrF     <= NOP_INSTR;
      r_pcF        <= RESET_PC;
      r_pc_plus4F  <= RESET_PC + PC_INC;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc    <= RESET_PC;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_pc   <= w_fetch_pc_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_validF     <= w_validF_nxt;
      r_instrF     <= w_instrF_nxt;
      r_pcF        <= w_pcF_nxt;
      r_pc_plus4F  <= w_pc_plus4F_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_pc_nxt   = r_fetch_pc;
    w_mem_req_nxt    = r_mem_req;
    w_mem_addr_nxt   = r_mem_addr;
    w_validF_nxt     = r_validF;
    w_instrF_nxt     = r_instrF;
    w_pcF_nxt        = r_pcF;
    w_pc_plus4F_nxt  = r_pc_plus4F;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc_nxt    = r_skid_pc;

    if (redirectE) begin
      w_validF_nxt   = 1'b0;
      w_instrF_nxt   = NOP_INSTR;
      w_fetch_pc_nxt = redirect_pcE;
      // An unacked request must stay on its old address; its response is thrown away in DROP
      if (r_mem_req && !mem_ack) begin
        w_state_nxt = S_DROP;
      end else begin
        w_state_nxt    = S_REQ;
        w_mem_req_nxt  = 1'b1;
        w_mem_addr_nxt = redirect_pcE;
      end
    end else begin
      if (w_f_accept) begin
        w_validF_nxt = 1'b0;
        w_instrF_nxt = NOP_INSTR;
      end else begin
        w_validF_nxt = r_validF;
      end

      case (r_state)
        S_IDLE: begin
          w_state_nxt    = S_REQ;
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = r_fetch_pc;
        end
        S_REQ: begin
          if (mem_ack) begin
            w_fetch_pc_nxt = r_mem_addr + PC_INC;
            if (w_f_accept) begin
              w_validF_nxt    = 1'b1;
              w_instrF_nxt    = mem_rdata;
              w_pcF_nxt       = r_mem_addr;
              w_pc_plus4F_nxt = r_mem_addr + PC_INC;
              w_mem_addr_nxt  = r_mem_addr + PC_INC;
            end else begin
              w_skid_instr_nxt = mem_rdata;
              w_skid_pc_nxt    = r_mem_addr;
              w_mem_req_nxt    = 1'b0;
              w_state_nxt      = S_SKID;
            end
          end else begin
            w_state_nxt = S_REQ;
          end
        end
        S_SKID: begin
          if (w_f_accept) begin
            w_validF_nxt    = 1'b1;
            w_instrF_nxt    = r_skid_instr;
            w_pcF_nxt       = r_skid_pc;
            w_pc_plus4F_nxt = r_skid_pc + PC_INC;
            w_state_nxt     = S_REQ;
            w_mem_req_nxt   = 1'b1;
            w_mem_addr_nxt  = r_fetch_pc;
          end else begin
            w_state_nxt = S_SKID;
          end
        end
        S_DROP: begin
          if (mem_ack) begin
            w_state_nxt    = S_REQ;
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = r_fetch_pc;
          end else begin
            w_state_nxt = S_DROP;
          end
        end
        default: begin
          w_state_nxt    = S_IDLE;
          w_mem_req_nxt  = 1'b0;
          w_mem_addr_nxt = r_fetch_pc;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign instrF    = r_instrF;
  assign pcF       = r_pcF;
  assign pc_plus4F = r_pc_plus4F;
  assign validF    = r_validF;

`ifdef FETCH_PERF_EN
  logic        w_drop_ack;
  logic [31:0] r_perf_bubbles;
  logic [31:0] r_perf_drops;

  // A response is discarded when it lands in DROP or together with a redirect
  assign w_drop_ack = r_mem_req && mem_ack && (redirectE || (r_state == S_DROP));

  // Saturating bubble and dropped-response counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_bubbles <= 32'd0;
      r_perf_drops   <= 32'd0;
    end else begin
      if (!r_validF && (r_perf_bubbles != 32'hFFFF_FFFF)) begin
        r_perf_bubbles <= r_perf_bubbles + 32'd1;
      end
      if (w_drop_ack && (r_perf_drops != 32'hFFFF_FFFF)) begin
        r_perf_drops <= r_perf_drops + 32'd1;
      end
    end
  end

  assign perf_bubbles = r_perf_bubbles;
  assign perf_drops   = r_perf_drops;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: an imem responder with configurable latency, a
// program-order reference queue, and a monitor that checks every instruction decode takes.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF;
  logic        redirectE;
  logic [31:0] redirect_pcE;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instrF;
  logic [31:0] pcF;
  logic [31:0] pc_plus4F;
  logic        validF;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallF       (stallF),
    .redirectE    (redirectE),
    .redirect_pcE (redirect_pcE),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .instrF       (instrF),
    .pcF          (pcF),
    .pc_plus4F    (pc_plus4F),
    .validF       (validF)
  );

  int          nvec = 0;
  int          nerr = 0;
  int          lat_mode = 0;      // fixed response latency, or -1 for random 0..3
  logic [31:0] exp_q[$];          // program order decode should see

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs for a cycle are driven 1 time unit after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit st, input bit rd, input logic [31:0] tgt);
    stallF       = st;
    redirectE    = rd;
    redirect_pcE = rd ? tgt : $urandom;
    if (rd) begin
      exp_q.delete();
      exp_q.push_back(tgt);
    end
    while (exp_q.size() < 2) exp_q.push_back(exp_q[$] + 32'd4);
  endtask

  task automatic step(input bit st, input bit rd, input logic [31:0] tgt);
    tick();
    drive(st, rd, tgt);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mem_req"},   {31'd0, mem_req}, 32'd0);
    check({tag, "_mem_addr"},  mem_addr,         32'd0);
    check({tag, "_validF"},    {31'd0, validF},  32'd0);
    check({tag, "_instrF"},    instrF,           NOP);
    check({tag, "_pcF"},       pcF,              32'd0);
    check({tag, "_pc_plus4F"}, pc_plus4F,        32'd4);
  endtask

  // imem responder: acks after lat_mode wait cycles and checks the request is held
  int          rsp_lat = 0;
  bit          rsp_active = 1'b0;
  logic [31:0] rsp_hold = 32'd0;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst || !mem_req) begin
        rsp_active = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = $urandom;
      end else begin
        if (!rsp_active) begin
          rsp_active = 1'b1;
          rsp_hold   = mem_addr;
          rsp_lat    = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        end else begin
          check("addr_stable", mem_addr, rsp_hold);
        end
        if (rsp_lat == 0) begin
          mem_ack    = 1'b1;
          mem_rdata  = memf(mem_addr);
          rsp_active = 1'b0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
          rsp_lat--;
        end
      end
    end
  end

  // Monitor: pops the reference on every instruction decode accepts
  int          wd = 0;
  logic [31:0] mon_exp;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst && validF && !stallF && !redirectE) begin
        mon_exp = exp_q.pop_front();
        check("pcF", pcF, mon_exp);
        check("instrF", instrF, memf(mon_exp));
        check("pc_plus4F", pc_plus4F, mon_exp + 32'd4);
        wd = 0;
      end else begin
        if (!validF) check("bubble_nop", instrF, NOP);
        if (!rst || (validF && stallF)) wd = 0;
        else wd++;
        if (wd > 40) begin
          nvec++;
          nerr++;
          $display("FAIL watchdog: %0d cycles without an instruction, required <= 40", wd);
          wd = 0;
        end
      end
    end
  end

  initial begin
    int  cnt;
    bit  found;
    rst          = 1'b0;
    stallF       = 1'b0;
    redirectE    = 1'b0;
    redirect_pcE = 32'd0;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);

    // Reset values, then 0-wait streaming from RESET_PC
    lat_mode = 0;
    repeat (3) step(1'b0, 1'b0, 32'd0);
    check_reset_vals("rst");
    rst = 1'b1;
    step(1'b0, 1'b0, 32'd0);
    check("c2_req",    {31'd0, mem_req}, 32'd1);
    check("c2_addr",   mem_addr,         32'd0);
    check("c2_valid",  {31'd0, validF},  32'd0);
    step(1'b0, 1'b0, 32'd0);
    check("c3_valid",  {31'd0, validF},  32'd1);
    check("c3_pc",     pcF,              32'h0);
    step(1'b0, 1'b0, 32'd0);
    check("c4_pc",     pcF,              32'h4);
    step(1'b0, 1'b0, 32'd0);
    check("c5_pc",     pcF,              32'h8);

    // 3-wait memory: one instruction every 4 cycles
    lat_mode = 3;
    repeat (8) step(1'b0, 1'b0, 32'd0);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 32'd0);
      if (validF) cnt++;
    end
    check("valid_rate", cnt, 32'd4);

    // Redirect to 0x100 while the 0x20 request waits
    step(1'b0, 1'b1, 32'h10);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (mem_req && !mem_ack && mem_addr == 32'h20) begin
        drive(1'b0, 1'b1, 32'h100);
        found = 1'b1;
      end else begin
        drive(1'b0, 1'b0, 32'd0);
      end
    end
    check("drop_setup", {31'd0, found}, 32'd1);
    step(1'b0, 1'b0, 32'd0);
    check("drop_hold_req",  {31'd0, mem_req}, 32'd1);
    check("drop_hold_addr", mem_addr,         32'h20);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 32'd0);
      found = validF;
    end
    check("drop_first_pc", pcF, 32'h100);

    // 5-cycle stall with a request in flight lands in the skid
    lat_mode = 1;
    repeat (6) step(1'b0, 1'b0, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = validF;
      drive(found, 1'b0, 32'd0);
    end
    check("stall_setup", {31'd0, found}, 32'd1);
    repeat (4) step(1'b1, 1'b0, 32'd0);
    check("skid_req_low", {31'd0, mem_req}, 32'd0);
    repeat (10) step(1'b0, 1'b0, 32'd0);

    // Redirect coincident with ack while decode stalls
    lat_mode = 0;
    repeat (4) step(1'b0, 1'b0, 32'd0);
    tick();
    check("coinc_ack", {31'd0, mem_req && mem_ack}, 32'd1);
    drive(1'b1, 1'b1, 32'h200);
    step(1'b0, 1'b0, 32'd0);
    check("coinc_valid", {31'd0, validF},  32'd0);
    check("coinc_req",   {31'd0, mem_req}, 32'd1);
    check("coinc_addr",  mem_addr,         32'h200);
    step(1'b0, 1'b0, 32'd0);
    check("redir_lat_valid", {31'd0, validF}, 32'd1);
    check("redir_lat_pc",    pcF,             32'h200);

    // Reset in the middle of a wait
    lat_mode = 3;
    repeat (6) step(1'b0, 1'b0, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = mem_req && !mem_ack;
      if (!found) drive(1'b0, 1'b0, 32'd0);
    end
    check("midrst_setup", {31'd0, found}, 32'd1);
    rst       = 1'b0;
    stallF    = 1'b0;
    redirectE = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    #1;
    check_reset_vals("midrst");
    repeat (2) step(1'b0, 1'b0, 32'd0);
    rst = 1'b1;
    step(1'b0, 1'b0, 32'd0);
    check("midrst_req",  {31'd0, mem_req}, 32'd1);
    check("midrst_addr", mem_addr,         32'd0);

    // Address wrap, then random traffic
    lat_mode = -1;
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (15) step(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) == 0, ($urandom % 25) == 0, 32'($urandom_range(0, 255)) << 2);
    end
    repeat (20) step(1'b0, 1'b0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
